sonar_scheduler: RTL and testbench
==================================

Name: sonar_scheduler

Overview:
- Sequences the five ultrasonic sonar channels in round-robin "low-performance" mode, so only one sonar transducer is active at a time and there is no acoustic crosstalk.
- Issues a one-cycle start pulse to one channel's sonar FSM, waits for that channel's completion or a timeout, inserts a guard gap, then moves to the next channel.
- A whole frame repeats on a fixed period.
- Sits between the free-running frame timer logic in the top level and the sonar FSM instances; replaces the shared all-channel trigger.

Parameters:
- N_SONARS, 5: number of channels sequenced.
- PERIOD_CYCLES, 3_000_000: frame period in CLOCK_50 cycles (60 ms).
- SLOT_TIMEOUT, 1_500_000: maximum wait per channel for done (30 ms).
- GAP_CYCLES, 50_000: guard gap after each slot (1 ms), for echo decay.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run frames continuously.
- done  in  N_SONARS  per-channel measurement-complete pulse from the sonar FSMs.
- clr_timeout  in  1  pulse; clears the timeout and overrun sticky flags.
- start  out  N_SONARS  one-hot, one-cycle start pulse to a sonar FSM.
- active_idx  out  3  index of the channel currently owning the slot.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame period completes.
- timeout  out  N_SONARS  sticky per-channel timeout flags.
- overrun  out  1  sticky; a frame's slots exceeded PERIOD_CYCLES.

Behaviour:
- Reset (async, active-high): state=IDLE; start=0; active_idx=0; busy=0; frame_done=0; timeout=0; overrun=0; all counters=0.
- Outputs are registered. A start pulse appears the cycle after the FSM enters FIRE.
- States are IDLE, FIRE, WAIT, GUARD, FRAME_WAIT.
- IDLE: when enable=1 -> FIRE with idx=0 and frame counter cleared.
- FIRE: exactly one cycle. Assert start[idx] for one cycle. Clear the slot counter. Go to WAIT.
- WAIT: slot counter increments each cycle.
  - done[idx]=1 -> GUARD.
  - Slot counter reaching SLOT_TIMEOUT-1 without done -> set timeout[idx], go to GUARD.
  - done and timeout in the same cycle: done wins; timeout is not set.
  - done on any channel other than idx is ignored in all states.
- GUARD: hold for GAP_CYCLES cycles.
  - Then, if idx<N_SONARS-1: idx+1, go to FIRE.
  - Otherwise go to FRAME_WAIT.
- FRAME_WAIT: wait until the frame counter reaches PERIOD_CYCLES-1.
  - Then pulse frame_done for one cycle.
  - If enable=1: idx=0, frame counter=0, go to FIRE. Otherwise go to IDLE.
- Frame counter: starts at 0 on the first FIRE of a frame and increments every cycle through FRAME_WAIT. Width is the ceiling of log2(PERIOD_CYCLES), i.e. 22 bits at default; it never wraps within a frame.
- Overrun: if the frame counter is already >= PERIOD_CYCLES-1 on leaving the last GUARD:
  - set overrun;
  - pulse frame_done on the next cycle;
  - start the next frame immediately.
- enable dropped mid-frame:
  - the current WAIT and GUARD complete normally;
  - at the end of GUARD -> IDLE;
  - no further start pulses and no frame_done for that frame.
- enable re-asserted while the in-progress slot is finishing: it has no effect until IDLE is reached.
- clr_timeout clears timeout and overrun. If a clear and a set occur in the same cycle, the set wins.
- active_idx is stable from FIRE through GUARD. busy=1 in FIRE, WAIT, GUARD and FRAME_WAIT.
- Reset asserted mid-slot returns to IDLE immediately; any in-flight start pulse is dropped.

Optional Feature:
- Macro: SONAR_SCHED_MASK_EN.
- When defined: adds input sonar_mask [N_SONARS-1:0].
  - Channels with mask bit=0 are skipped with no FIRE, WAIT or GUARD.
  - The mask is sampled at frame start and held for the whole frame.
  - All-zero mask: go straight to FRAME_WAIT; frame_done still pulses every period.
- When undefined: the port is absent and all channels are always sequenced.

Test Plan:
Simulation parameters: PERIOD_CYCLES=1000, SLOT_TIMEOUT=200, GAP_CYCLES=10.
- Reset then enable=1; each done[i] returned 50 cycles after start[i] -> start pulses on channels 0..4 in order, 61 cycles apart (FIRE, then done after 50 WAIT cycles, then 10 GUARD). frame_done pulses at frame-counter 999. timeout=0.
- Hold done[2] low -> timeout[2] set after 200 WAIT cycles. Channels 3 and 4 still fire. clr_timeout -> timeout=0.
- Raise done[3] while active_idx=1 -> ignored; channel 1 still times out at 200 cycles if its own done never comes.
- Raise done[idx] on the same cycle the slot counter reaches 199 -> no timeout bit set.
- Return no done on any channel (5 × ~211 cycles > 1000) -> overrun=1; frame_done pulses immediately after the last GUARD; next start[0] follows with no idle gap.
- Drop enable during channel 1's WAIT -> channel 1 completes plus GUARD, then busy=0, start[2] never pulses, no frame_done. Assert reset mid-WAIT -> all outputs 0 on the same cycle.

Source files
------------

// File: rtl/sonar_scheduler_if.sv
// rtl/sonar_scheduler_if.sv - Handshake bundle between frame logic and sonar_scheduler.
// Optional macro SONAR_SCHED_MASK_EN adds the sonar_mask channel-enable vector.
interface sonar_scheduler_if #(
    parameter int N_SONARS = 5
);
    logic                enable;
    logic [N_SONARS-1:0] done;
    logic                clr_timeout;
`ifdef SONAR_SCHED_MASK_EN
    logic [N_SONARS-1:0] sonar_mask;
`endif
    logic [N_SONARS-1:0] start;
    logic [2:0]          active_idx;
    logic                busy;
    logic                frame_done;
    logic [N_SONARS-1:0] timeout;
    logic                overrun;

    modport master (
`ifdef SONAR_SCHED_MASK_EN
        output sonar_mask,
`endif
        output enable, done, clr_timeout,
        input  start, active_idx, busy, frame_done, timeout, overrun
    );

    modport slave (
`ifdef SONAR_SCHED_MASK_EN
        input  sonar_mask,
`endif
        input  enable, done, clr_timeout,
        output start, active_idx, busy, frame_done, timeout, overrun
    );
endinterface

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - Round-robin sonar channel sequencer with per-slot timeout and guard gap.
// Optional macro SONAR_SCHED_MASK_EN skips channels whose mask bit is 0.
module sonar_scheduler #(
    parameter int N_SONARS      = 5,
    parameter int PERIOD_CYCLES = 3_000_000,
    parameter int SLOT_TIMEOUT  = 1_500_000,
    parameter int GAP_CYCLES    = 50_000
) (
    input logic              CLOCK_50,
    input logic              reset,
    sonar_scheduler_if.slave bus
);
    localparam int FW = $clog2(PERIOD_CYCLES);
    localparam int CW = $clog2((SLOT_TIMEOUT > GAP_CYCLES) ? SLOT_TIMEOUT : GAP_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_FIRE, S_WAIT, S_GUARD, S_FRAME_WAIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_idx, w_idx_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [FW-1:0]       r_frame, w_frame_nxt;
    logic [N_SONARS-1:0] r_start, w_start_nxt;
    logic                r_frame_done, w_frame_done_nxt;
    logic [N_SONARS-1:0] r_timeout, w_to_set;
    logic                r_overrun, w_ovr_set;
    logic                r_stop, w_stop_nxt;
    logic                w_restart;
    logic                w_first_found, w_next_found;
    logic [2:0]          w_first_idx, w_next_idx;
`ifdef SONAR_SCHED_MASK_EN
    logic [N_SONARS-1:0] r_mask, w_mask_nxt;
`endif

    // First channel of a new frame, and the channel after the current one.
    always_comb begin
`ifdef SONAR_SCHED_MASK_EN
        w_first_found = 1'b0;
        w_first_idx   = '0;
        w_next_found  = 1'b0;
        w_next_idx    = '0;
        for (int i = N_SONARS - 1; i >= 0; i--) begin
            if (bus.sonar_mask[i]) begin
                w_first_found = 1'b1;
                w_first_idx   = 3'(i);
            end
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_next_found = 1'b1;
                w_next_idx   = 3'(i);
            end
        end
`else
        w_first_found = 1'b1;
        w_first_idx   = '0;
        w_next_found  = (r_idx < 3'(N_SONARS - 1));
        w_next_idx    = r_idx + 3'd1;
`endif
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_cnt_nxt        = r_cnt;
        w_frame_nxt      = (r_frame == FRAME_LAST) ? r_frame : r_frame + 1'b1;
        w_start_nxt      = '0;
        w_frame_done_nxt = 1'b0;
        w_to_set         = '0;
        w_ovr_set        = 1'b0;
        w_stop_nxt       = r_stop | ~bus.enable;
        w_restart        = 1'b0;
`ifdef SONAR_SCHED_MASK_EN
        w_mask_nxt       = r_mask;
`endif
        case (r_state)
            S_IDLE: begin
                w_stop_nxt  = 1'b0;
                w_frame_nxt = '0;
                w_restart   = bus.enable;
            end
            S_FIRE: begin
                w_start_nxt[r_idx] = 1'b1;
                w_cnt_nxt          = '0;
                w_state_nxt        = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (bus.done[r_idx]) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GUARD;
                end else if (r_cnt == SLOT_LAST) begin
                    w_to_set[r_idx] = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_GUARD;
                end
            end
            S_GUARD: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_stop_nxt) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_next_found) begin
                        w_state_nxt = S_FIRE;
                        w_idx_nxt   = w_next_idx;
                    end else if (r_frame >= FRAME_LAST) begin
                        // Slots ran past the period: close the frame now and restart.
                        w_ovr_set        = 1'b1;
                        w_frame_done_nxt = 1'b1;
                        w_restart        = 1'b1;
                    end else begin
                        w_state_nxt = S_FRAME_WAIT;
                    end
                end
            end
            S_FRAME_WAIT: begin
                if (r_frame == FRAME_LAST) begin
                    w_frame_done_nxt = 1'b1;
                    if (w_stop_nxt) w_state_nxt = S_IDLE;
                    else            w_restart   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_restart) begin
            w_frame_nxt = '0;
            w_idx_nxt   = w_first_idx;
            w_state_nxt = w_first_found ? S_FIRE : S_FRAME_WAIT;
`ifdef SONAR_SCHED_MASK_EN
            w_mask_nxt  = bus.sonar_mask;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_frame      <= '0;
            r_start      <= '0;
            r_frame_done <= 1'b0;
            r_timeout    <= '0;
            r_overrun    <= 1'b0;
            r_stop       <= 1'b0;
`ifdef SONAR_SCHED_MASK_EN
            r_mask       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_frame      <= w_frame_nxt;
            r_start      <= w_start_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_timeout    <= (r_timeout & ~{N_SONARS{bus.clr_timeout}}) | w_to_set;
            r_overrun    <= (r_overrun & ~bus.clr_timeout) | w_ovr_set;
            r_stop       <= w_stop_nxt;
`ifdef SONAR_SCHED_MASK_EN
            r_mask       <= w_mask_nxt;
`endif
        end
    end

    assign bus.start      = r_start;
    assign bus.active_idx = r_idx;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.timeout    = r_timeout;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - Directed self-checking bench for sonar_scheduler.
module tb_sonar_scheduler;
    logic clk;
    logic reset;
    logic [4:0] resp_done;
    logic [4:0] force_done;
    int   resp_dly [5];
    int   cd [5];
    int   cyc;
    int   start_total;
    int   fd_total;
    int   n_checks;
    int   n_pass;

    sonar_scheduler_if #(.N_SONARS(5)) bus ();

    sonar_scheduler #(
        .N_SONARS     (5),
        .PERIOD_CYCLES(1000),
        .SLOT_TIMEOUT (200),
        .GAP_CYCLES   (10)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    assign bus.done = resp_done | force_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc         = 0;
        start_total = 0;
        fd_total    = 0;
        resp_done   = '0;
        for (int i = 0; i < 5; i++) cd[i] = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Echo model: answers each start with done a fixed number of cycles later.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            resp_done[i] = 1'b0;
            if (cd[i] == 1) begin
                resp_done[i] = 1'b1;
                cd[i] = 0;
            end else if (cd[i] > 1) begin
                cd[i] = cd[i] - 1;
            end
            if (bus.start[i] && resp_dly[i] != 0) cd[i] = resp_dly[i];
        end
        start_total = start_total + $countones(bus.start);
        fd_total    = fd_total + int'(bus.frame_done);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_start(input int ch, output int c);
        int k;
        k = 0;
        c = -1;
        while (!bus.start[ch] && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("start%0d_seen", ch), 32'(bus.start[ch]), 1);
        if (bus.start[ch]) c = cyc;
    endtask

    task automatic wait_fd(output int c);
        int k;
        k = 0;
        c = -1;
        while (!bus.frame_done && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_seen", 32'(bus.frame_done), 1);
        if (bus.frame_done) c = cyc;
    endtask

    initial begin
        int a0, b0, c0, d0, e0, t, prev, f, n_st, n_fd;
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.clr_timeout = 1'b0;
        force_done      = '0;
        for (int i = 0; i < 5; i++) resp_dly[i] = 49;

        repeat (3) @(negedge clk);
        check("rst_start",      32'(bus.start), 0);
        check("rst_active_idx", 32'(bus.active_idx), 0);
        check("rst_busy",       32'(bus.busy), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_timeout",    32'(bus.timeout), 0);
        check("rst_overrun",    32'(bus.overrun), 0);
        reset = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;

        // Frame A: every channel answers 50 cycles into its WAIT.
        wait_start(0, a0);
        prev = a0;
        for (int i = 1; i < 5; i++) begin
            wait_start(i, t);
            check($sformatf("A_gap%0d", i), t - prev, 61);
            prev = t;
        end
        wait_fd(f);
        check("A_fd_at",   f - a0, 999);
        check("A_timeout", 32'(bus.timeout), 0);
        check("A_overrun", 32'(bus.overrun), 0);
        resp_dly[2] = 0;
        @(negedge clk);
        check("A_fd_width", 32'(bus.frame_done), 0);

        // Frame B: channel 2 silent -> timeout after 200 WAIT cycles.
        wait_start(0, b0);
        check("B_period", b0 - a0, 1000);
        wait_start(2, t);
        check("B_start2", t - b0, 122);
        repeat (199) @(negedge clk);
        check("B_to_before", 32'(bus.timeout), 0);
        @(negedge clk);
        check("B_to_set", 32'(bus.timeout), 32'b00100);
        prev = t;
        wait_start(3, t);
        check("B_gap_after_to", t - prev, 211);
        prev = t;
        wait_start(4, t);
        check("B_gap4", t - prev, 61);
        wait_fd(f);
        check("B_fd_at", f - b0, 999);
        resp_dly[2] = 49;
        resp_dly[1] = 0;
        bus.clr_timeout = 1'b1;
        @(negedge clk);
        bus.clr_timeout = 1'b0;
        check("C_clr", 32'(bus.timeout), 0);

        // Frame C: foreign done ignored; done on the last slot cycle beats timeout.
        wait_start(0, c0);
        check("C_period", c0 - b0, 1000);
        wait_start(1, t);
        check("C_gap1", t - c0, 61);
        prev = t;
        repeat (20) @(negedge clk);
        force_done = 5'b01000;
        @(negedge clk);
        force_done = '0;
        resp_dly[3] = 0;
        wait_start(2, t);
        check("C_foreign_done", t - prev, 211);
        check("C_to1", 32'(bus.timeout), 32'b00010);
        prev = t;
        wait_start(3, t);
        check("C_gap3", t - prev, 61);
        repeat (199) @(negedge clk);
        force_done = 5'b01000;
        @(negedge clk);
        force_done = '0;
        prev = t;
        wait_start(4, t);
        check("C_done_at_last", t - prev, 211);
        check("C_done_wins", 32'(bus.timeout), 32'b00010);
        wait_fd(f);
        check("C_fd_at", f - c0, 999);
        for (int i = 0; i < 5; i++) resp_dly[i] = 0;
        bus.clr_timeout = 1'b1;
        @(negedge clk);
        bus.clr_timeout = 1'b0;
        check("D_clr", 32'(bus.timeout), 0);

        // Frame D: nobody answers -> overrun, immediate frame_done and restart.
        wait_start(0, d0);
        check("D_period", d0 - c0, 1000);
        wait_start(4, t);
        check("D_start4", t - d0, 844);
        wait_fd(f);
        check("D_fd_at",   f - d0, 1054);
        check("D_overrun", 32'(bus.overrun), 1);
        check("D_to_all",  32'(bus.timeout), 32'b11111);
        for (int i = 0; i < 5; i++) resp_dly[i] = 49;
        @(negedge clk);
        check("D_fd_width", 32'(bus.frame_done), 0);
        wait_start(0, e0);
        check("E_no_gap", e0 - f, 1);

        // Frame E: enable dropped (and briefly re-raised) during channel 1 WAIT.
        wait_start(1, t);
        repeat (10) @(negedge clk);
        bus.enable = 1'b0;
        repeat (20) @(negedge clk);
        bus.enable = 1'b1;
        repeat (10) @(negedge clk);
        bus.enable = 1'b0;
        repeat (19) @(negedge clk);
        check("E_busy_guard", 32'(bus.busy), 1);
        check("E_idx_guard",  32'(bus.active_idx), 1);
        @(negedge clk);
        check("E_busy_idle", 32'(bus.busy), 0);
        n_st = start_total;
        n_fd = fd_total;
        repeat (1200) @(negedge clk);
        check("E_no_start", start_total - n_st, 0);
        check("E_no_fd",    fd_total - n_fd, 0);

        // Reset in the middle of a start pulse clears everything at once.
        bus.enable = 1'b1;
        wait_start(0, t);
        check("G_overrun_held", 32'(bus.overrun), 1);
        reset = 1'b1;
        #1;
        check("G_rst_start",   32'(bus.start), 0);
        check("G_rst_busy",    32'(bus.busy), 0);
        check("G_rst_timeout", 32'(bus.timeout), 0);
        check("G_rst_overrun", 32'(bus.overrun), 0);
        check("G_rst_idx",     32'(bus.active_idx), 0);
        @(negedge clk);
        reset      = 1'b0;
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
